// File: rtl/uart_sram_pkg.sv
// Shared definitions for the UART SRAM-loader protocol (host and chip side).
// Optional build macro: UART_HOST_CHECKSUM_EN adds an XOR checksum byte to
// every frame and to read responses.
package uart_sram_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_RUN   = 8'h47;

`ifdef UART_HOST_CHECKSUM_EN
  localparam int RSP_BYTES = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_SEND_ADDR, S_SEND_DATA, S_SEND_CSUM, S_WAIT_RX, S_DONE
  } state_t;
`else
  localparam int RSP_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_SEND_ADDR, S_SEND_DATA, S_WAIT_RX, S_DONE
  } state_t;
`endif

  // Command byte that opens the frame for a given op.
  function automatic logic [7:0] cmd_byte(input logic [1:0] op);
    case (op)
      OP_WRITE: cmd_byte = CMD_WRITE;
      OP_READ:  cmd_byte = CMD_READ;
      default:  cmd_byte = CMD_RUN;
    endcase
  endfunction

endpackage

// File: rtl/uart_sram_host_timeout.sv
// Inter-byte response timeout: loadable down-counter, expired at zero.
module uart_sram_host_timeout #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Reload on every received byte (and while not waiting); count down otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= '0;
    else if (load)          count <= LOAD_VAL;
    else if (count != '0)   count <= count - CW'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_sram_host.sv
// Host-side initiator for the UART SRAM-loader protocol: serialises word
// requests into byte frames and reassembles read responses.
// Optional build macro: UART_HOST_CHECKSUM_EN (XOR checksum byte per frame
// and per read response).
//
// state       | meaning
// ------------+----------------------------------------------------
// S_IDLE      | ready for a request
// S_SEND_CMD  | offering the command byte
// S_SEND_ADDR | offering the address byte (0x00 for RUN)
// S_SEND_DATA | offering write data bytes, little-endian, cnt 0..3
// S_SEND_CSUM | offering XOR of all previous frame bytes (macro only)
// S_WAIT_RX   | collecting response bytes, guarded by the timeout
// S_DONE      | one-cycle rsp_valid pulse
module uart_sram_host
  import uart_sram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int ADDR_W         = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              rx_enable,
  output logic              rx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              busy
);

  state_t            state, state_n;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        cnt, cnt_n;
  logic [31:0]       sh, sh_n;
  logic              done_err;
  logic              latch;
  logic              expired;
`ifdef UART_HOST_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign rx_enable = 1'b1;
  assign busy      = (state != S_IDLE);

  uart_sram_host_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    ((state != S_WAIT_RX) || rx_valid),
    .expired (expired)
  );

  // Next-state, byte selection and handshake outputs.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = sh;
    done_err  = 1'b0;
    latch     = 1'b0;
    req_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    rx_ready  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        cnt_n     = '0;
        if (req_valid) begin
          latch = 1'b1;
          sh_n  = '0;
          if (req_op == OP_RSVD) begin
            state_n  = S_DONE;
            done_err = 1'b1;
          end else begin
            state_n = S_SEND_CMD;
          end
        end
      end
      S_SEND_CMD: begin
        tx_valid = 1'b1;
        tx_data  = cmd_byte(op_q);
        if (tx_ready) state_n = S_SEND_ADDR;
      end
      S_SEND_ADDR: begin
        tx_valid = 1'b1;
        tx_data  = (op_q == OP_RUN) ? 8'h00 : 8'(addr_q);
        if (tx_ready) begin
          if (op_q == OP_WRITE)     state_n = S_SEND_DATA;
`ifdef UART_HOST_CHECKSUM_EN
          else                      state_n = S_SEND_CSUM;
`else
          else if (op_q == OP_READ) state_n = S_WAIT_RX;
          else                      state_n = S_DONE;
`endif
        end
      end
      S_SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = wdata_q[cnt[1:0]*8 +: 8];
        if (tx_ready) begin
          if (cnt[1:0] == 2'd3) begin
            cnt_n = '0;
`ifdef UART_HOST_CHECKSUM_EN
            state_n = S_SEND_CSUM;
`else
            state_n = S_DONE;
`endif
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
`ifdef UART_HOST_CHECKSUM_EN
      S_SEND_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) state_n = (op_q == OP_READ) ? S_WAIT_RX : S_DONE;
      end
`endif
      S_WAIT_RX: begin
        rx_ready = 1'b1;
        // A byte arriving on the expiry cycle still counts.
        if (rx_valid) begin
          if (cnt < 3'd4) sh_n[cnt[1:0]*8 +: 8] = rx_data;
          if (cnt == 3'(RSP_BYTES - 1)) begin
            state_n = S_DONE;
            cnt_n   = '0;
`ifdef UART_HOST_CHECKSUM_EN
            done_err = (rx_data != (sh[7:0] ^ sh[15:8] ^ sh[23:16] ^ sh[31:24]));
`endif
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end else if (expired) begin
          state_n  = S_DONE;
          done_err = 1'b1;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, request capture, receive shift register and held response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= '0;
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      if (latch) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if ((state_n == S_DONE) && (state != S_DONE)) begin
        rsp_rdata <= sh_n;
        rsp_err   <= done_err;
      end
    end
  end

`ifdef UART_HOST_CHECKSUM_EN
  // Running XOR of the bytes accepted so far in the current frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    csum <= '0;
    else if (state == S_IDLE)     csum <= '0;
    else if (tx_valid && tx_ready) csum <= csum ^ tx_data;
  end
`endif

endmodule

// File: tb/tb_uart_sram_host.sv
// Scoreboard bench for uart_sram_host (TIMEOUT_CYCLES=50, ADDR_W=5).
`timescale 1ns/1ps
module tb_uart_sram_host;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_enable, rx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic        busy;

  uart_sram_host #(.TIMEOUT_CYCLES(TO), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_enable(rx_enable), .rx_ready(rx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;   // cycles from ref_cyc to rsp_valid, -1 = unchecked
  } rsp_t;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];
  int         checks = 0;
  int         passes = 0;
  int         rsp_count = 0;
  int         ref_cyc = 0;
  logic [7:0] run_csum = 8'h00;
  logic [7:0] mon_b;
  rsp_t       mon_r;

`ifdef UART_HOST_CHECKSUM_EN
  localparam int FRAME_EXTRA = 1;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: pops the scoreboard on every tx handshake and every response.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++;
          $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
        end else begin
          mon_b = exp_tx.pop_front();
          check("tx_byte", tx_data, mon_b);
        end
      end
      if (rsp_valid) begin
        rsp_count++;
        if (exp_rsp.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: got rdata %h err %b expected none", rsp_rdata, rsp_err);
        end else begin
          mon_r = exp_rsp.pop_front();
          check("rsp_rdata", rsp_rdata, mon_r.rdata);
          check("rsp_err", rsp_err, mon_r.err);
          if (mon_r.lat >= 0) check("rsp_latency", cyc - ref_cyc, mon_r.lat);
        end
      end
    end
  end

  task automatic push_tx(input logic [7:0] b);
    exp_tx.push_back(b);
    run_csum ^= b;
  endtask

  task automatic end_frame();
`ifdef UART_HOST_CHECKSUM_EN
    exp_tx.push_back(run_csum);
`endif
    run_csum = 8'h00;
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e, input int lat);
    rsp_t r;
    r.rdata = d; r.err = e; r.lat = lat;
    exp_rsp.push_back(r);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        ref_cyc = cyc;
        return;
      end
    end
    req_valid = 1'b0;
    checks++;
    $display("FAIL req_accept: req_ready stayed 0 expected 1");
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 400; i++) begin
      if (rsp_count >= target) return;
      @(negedge clk);
    end
    checks++;
    $display("FAIL rsp_wait: got %0d responses expected %0d", rsp_count, target);
  endtask

  task automatic wait_rx_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_ready) return;
    end
    checks++;
    $display("FAIL rx_ready_wait: got 0 expected 1");
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1 rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    ref_cyc = cyc;
  endtask

  // Appends the response checksum byte when that build option is on.
  task automatic send_rx_csum(input logic [31:0] d, input int gap);
`ifdef UART_HOST_CHECKSUM_EN
    send_rx(d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24], gap);
`endif
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_enable", rx_enable, 1);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    tx_ready = 1; rx_valid = 0; rx_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1 reset = 1'b0;

    // WRITE 03 / DEADBEEF, no backpressure
    push_tx(8'h57); push_tx(8'h03); push_tx(8'hEF); push_tx(8'hBE); push_tx(8'hAD); push_tx(8'hDE);
    end_frame();
    push_rsp(32'h0, 1'b0, 6 + FRAME_EXTRA);
    do_req(2'd0, 5'h03, 32'hDEADBEEF);
    wait_rsp(1);

    // byte arriving while idle is dropped
    send_rx(8'h99, 2);
    check("idle_busy", busy, 0);

    // READ 1F, response 78 56 34 12 with 40-cycle gaps
    push_tx(8'h52); push_tx(8'h1F); end_frame();
    push_rsp(32'h12345678, 1'b0, 0);
    do_req(2'd1, 5'h1F, 32'h0);
    wait_rx_ready();
    send_rx(8'h78, 40); send_rx(8'h56, 40); send_rx(8'h34, 40); send_rx(8'h12, 40);
    send_rx_csum(32'h12345678, 40);
    wait_rsp(2);

    // READ 05, each byte lands on the expiry cycle: byte wins
    push_tx(8'h52); push_tx(8'h05); end_frame();
    push_rsp(32'h44332211, 1'b0, 0);
    do_req(2'd1, 5'h05, 32'h0);
    wait_rx_ready();
    send_rx(8'h11, TO - 1); send_rx(8'h22, TO - 1); send_rx(8'h33, TO - 1); send_rx(8'h44, TO - 1);
    send_rx_csum(32'h44332211, TO - 1);
    wait_rsp(3);

    // READ 02, only two bytes returned: timeout TO cycles after the last one
    push_tx(8'h52); push_tx(8'h02); end_frame();
    push_rsp(32'h0000BBAA, 1'b1, TO);
    do_req(2'd1, 5'h02, 32'h0);
    wait_rx_ready();
    send_rx(8'hAA, 5); send_rx(8'hBB, 5);
    wait_rsp(4);

    // WRITE with tx_ready low for 20 cycles on the command byte
    tx_ready = 1'b0;
    push_tx(8'h57); push_tx(8'h0A); push_tx(8'h44); push_tx(8'h33); push_tx(8'h22); push_tx(8'h11);
    end_frame();
    push_rsp(32'h0, 1'b0, -1);
    do_req(2'd0, 5'h0A, 32'h11223344);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_tx_valid", tx_valid, 1);
      check("stall_tx_data", tx_data, 8'h57);
      check("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_rsp(5);

    // reserved op: error response, nothing transmitted
    push_rsp(32'h0, 1'b1, 0);
    do_req(2'd3, 5'h00, 32'h0);
    wait_rsp(6);

    // reset during SEND_DATA byte 2 of a WRITE
    push_tx(8'h57); push_tx(8'h07); push_tx(8'h0D); push_tx(8'hF0);
    run_csum = 8'h00;
    do_req(2'd0, 5'h07, 32'hCAFEF00D);
    repeat (4) @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    check("abort_pre_tx_data", tx_data, 8'hFE);
    check("abort_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("abort_no_rsp", rsp_count, 6);

    // RUN after the abort
    push_tx(8'h47); push_tx(8'h00); end_frame();
    push_rsp(32'h0, 1'b0, 2 + FRAME_EXTRA);
    do_req(2'd2, 5'h1C, 32'h0);
    wait_rsp(7);

`ifdef UART_HOST_CHECKSUM_EN
    // hand-computed checksum frames
    exp_tx.push_back(8'h57); exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h56);
    push_rsp(32'h0, 1'b0, 7);
    do_req(2'd0, 5'h01, 32'h0);
    wait_rsp(8);

    exp_tx.push_back(8'h52); exp_tx.push_back(8'h04); exp_tx.push_back(8'h56);
    push_rsp(32'h04030201, 1'b1, 0);
    do_req(2'd1, 5'h04, 32'h0);
    wait_rx_ready();
    send_rx(8'h01, 3); send_rx(8'h02, 3); send_rx(8'h03, 3); send_rx(8'h04, 3); send_rx(8'h05, 3);
    wait_rsp(9);
`endif

    repeat (5) @(posedge clk);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
